// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control unit (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//
// Build option: define CTRL_TRAP_EN so that an illegal opcode parks the FSM in TRAP
// (trap=1) until rst. Without it, an illegal opcode retires as a NOP (PC+4, no RF write)
// and trap is tied to 0.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   opcode[6:0]              IR[6:0], stable from DECODE onward
//   branch_taken             datapath comparator result, used in EXEC
//   imem_ready, dmem_ready   memory completion strobes
//   imem_req, dmem_req       memory requests, held until ready or timeout
//   we_DM, we_IM             data / instruction memory writes (we_IM tied 0)
//   sel_ALU_A, sel_ALU_B     ALU operands: A 0=rs1 1=PC, B 0=rs2 1=imm
//   sel_PC_A, sel_PC_B       PC adder: A 0=PC 1=rs1, B 0=+4 1=+imm
//   load_IR, load_PC, we_RF  register load enables
//   sel_imme[2:0]            immediate format 0=I 1=S 2=B 3=J 4=U
//   sel_RF_in[1:0]           RF write source 0=ALU 1=DM 2=PC+4 3=imm
//   bus_err                  one-cycle pulse on memory timeout
//   trap                     illegal-opcode indication
//   state[2:0]               current state, for debug
module controle_multiciclo #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       we_DM,
   output logic       we_IM,
   output logic       sel_ALU_A,
   output logic       sel_ALU_B,
   output logic       sel_PC_A,
   output logic       sel_PC_B,
   output logic       load_IR,
   output logic       load_PC,
   output logic       we_RF,
   output logic [2:0] sel_imme,
   output logic [1:0] sel_RF_in,
   output logic       bus_err,
   output logic       trap,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpLui    = 7'b0110111;

   localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui;
   logic is_legal;
   logic timeout;

   assign is_r      = (opcode == OpR);
   assign is_i      = (opcode == OpI);
   assign is_load   = (opcode == OpLoad);
   assign is_store  = (opcode == OpStore);
   assign is_branch = (opcode == OpBranch);
   assign is_jal    = (opcode == OpJal);
   assign is_jalr   = (opcode == OpJalr);
   assign is_auipc  = (opcode == OpAuipc);
   assign is_lui    = (opcode == OpLui);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr |
                      is_auipc | is_lui;

   // Counter value equals the number of cycles already spent waiting in this attempt.
   assign timeout = (cnt_q == TimeoutCnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are decoded from the registered state; the ready strobes qualify the
   // completion-cycle enables so a memory handshake finishes in the cycle it arrives.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;  // any state change (including a timeout retry) clears the counter
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      we_DM     = 1'b0;
      sel_ALU_A = 1'b0;
      sel_ALU_B = 1'b0;
      sel_PC_A  = 1'b0;
      sel_PC_B  = 1'b0;
      load_IR   = 1'b0;
      load_PC   = 1'b0;
      we_RF     = 1'b0;
      sel_imme  = 3'd0;
      sel_RF_in = 2'd0;
      bus_err   = 1'b0;

      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               load_IR = 1'b1;
               state_d = StDecode;
            end else if (timeout) begin
               bus_err = 1'b1;
               state_d = StFetch;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         StDecode: begin
            if (is_legal) begin
               state_d = StExec;
            end else begin
`ifdef CTRL_TRAP_EN
               state_d = StTrap;
`else
               state_d = StWb;
`endif
            end
         end

         StExec: begin
            if (is_i || is_load || is_jalr) begin
               sel_ALU_B = 1'b1;
               sel_imme  = 3'd0;
            end else if (is_store) begin
               sel_ALU_B = 1'b1;
               sel_imme  = 3'd1;
            end else if (is_auipc) begin
               sel_ALU_A = 1'b1;
               sel_ALU_B = 1'b1;
               sel_imme  = 3'd4;
            end else if (is_lui) begin
               sel_imme = 3'd4;
            end else if (is_jal) begin
               sel_imme = 3'd3;
            end else if (is_branch) begin
               sel_imme = 3'd2;
               load_PC  = 1'b1;
               sel_PC_B = branch_taken;
            end

            if (is_load || is_store) begin
               state_d = StMem;
            end else if (is_branch) begin
               state_d = StFetch;
            end else begin
               state_d = StWb;
            end
         end

         StMem: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               if (is_store) begin
                  we_DM   = 1'b1;
                  load_PC = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (timeout) begin
               // Abort with PC untouched so the instruction is fetched again.
               bus_err = 1'b1;
               state_d = StFetch;
            end else begin
               we_DM = is_store;
               cnt_d = cnt_q + 8'd1;
            end
         end

         StWb: begin
            load_PC = 1'b1;
            we_RF   = is_legal;  // illegal opcodes only get here as a NOP
            state_d = StFetch;
            if (is_load) begin
               sel_RF_in = 2'd1;
            end else if (is_lui) begin
               sel_RF_in = 2'd3;
            end else if (is_jal) begin
               sel_RF_in = 2'd2;
               sel_PC_B  = 1'b1;
               sel_imme  = 3'd3;
            end else if (is_jalr) begin
               sel_RF_in = 2'd2;
               sel_PC_A  = 1'b1;
               sel_PC_B  = 1'b1;
               sel_imme  = 3'd0;
            end
         end

         StTrap: begin
`ifdef CTRL_TRAP_EN
            state_d = StTrap;
`else
            state_d = StFetch;
`endif
         end

         default: state_d = StFetch;
      endcase
   end

`ifdef CTRL_TRAP_EN
   assign trap = (state_q == StTrap);
`else
   assign trap = 1'b0;
`endif

   assign we_IM = 1'b0;
   assign state = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Testbench for controle_multiciclo: transaction-level reference model builds the expected
// per-cycle output trace of each instruction, which is then compared against the DUT.
module tb_controle_multiciclo;

   localparam int T = 15;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpI      = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpIll    = 7'b1111111;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       we_DM;
      logic       we_IM;
      logic       sel_ALU_A;
      logic       sel_ALU_B;
      logic       sel_PC_A;
      logic       sel_PC_B;
      logic       load_IR;
      logic       load_PC;
      logic       we_RF;
      logic [2:0] sel_imme;
      logic [1:0] sel_RF_in;
      logic       bus_err;
      logic       trap;
      logic [2:0] state;
   } out_t;

   typedef struct packed {
      logic [6:0] op;
      logic       bt;
      logic       ir;
      logic       dr;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       branch_taken, imem_ready, dmem_ready;
   logic       imem_req, dmem_req, we_DM, we_IM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B;
   logic       load_IR, load_PC, we_RF, bus_err, trap;
   logic [2:0] sel_imme, state;
   logic [1:0] sel_RF_in;

   int    checks = 0;
   int    failures = 0;
   out_t  obs;
   stim_t sq[$];
   out_t  eq[$];
   logic [6:0] legal_ops [9] = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr,
                                  OpAuipc, OpLui};

   always #5 clk = ~clk;

   controle_multiciclo #(.MEM_TIMEOUT(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .imem_req     (imem_req),
      .dmem_req     (dmem_req),
      .we_DM        (we_DM),
      .we_IM        (we_IM),
      .sel_ALU_A    (sel_ALU_A),
      .sel_ALU_B    (sel_ALU_B),
      .sel_PC_A     (sel_PC_A),
      .sel_PC_B     (sel_PC_B),
      .load_IR      (load_IR),
      .load_PC      (load_PC),
      .we_RF        (we_RF),
      .sel_imme     (sel_imme),
      .sel_RF_in    (sel_RF_in),
      .bus_err      (bus_err),
      .trap         (trap),
      .state        (state)
   );

   // ---------------- reference model ----------------
   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpAuipc, OpLui};
   endfunction

   function automatic out_t base(input logic [2:0] st);
      out_t o = '0;
      o.state = st;
      return o;
   endfunction

   // Inputs the DUT must ignore in the given cycle are randomized.
   function automatic stim_t junk(input logic [6:0] op);
      stim_t s;
      s.op = op;
      s.bt = 1'($urandom);
      s.ir = 1'($urandom);
      s.dr = 1'($urandom);
      return s;
   endfunction

   task automatic push(input stim_t s, input out_t e);
      sq.push_back(s);
      eq.push_back(e);
   endtask

   // Fetch with imem_ready arriving after fw idle cycles; each attempt lasts at most T+1
   // cycles, the last of which reports bus_err and restarts the wait.
   task automatic m_fetch(input int fw);
      int    w = fw;
      stim_t s;
      out_t  e;
      while (w > T) begin
         for (int i = 0; i <= T; i++) begin
            s = junk(7'($urandom)); s.ir = 1'b0;
            e = base(3'd0); e.imem_req = 1'b1; e.bus_err = (i == T);
            push(s, e);
         end
         w -= T + 1;
      end
      for (int i = 0; i < w; i++) begin
         s = junk(7'($urandom)); s.ir = 1'b0;
         e = base(3'd0); e.imem_req = 1'b1;
         push(s, e);
      end
      s = junk(7'($urandom)); s.ir = 1'b1;
      e = base(3'd0); e.imem_req = 1'b1; e.load_IR = 1'b1;
      push(s, e);
   endtask

   task automatic m_decode(input logic [6:0] op);
      push(junk(op), base(3'd1));
   endtask

   task automatic m_exec(input logic [6:0] op, input logic bt);
      stim_t s = junk(op);
      out_t  e = base(3'd2);
      s.bt = bt;
      case (op)
         OpI, OpLoad, OpJalr: e.sel_ALU_B = 1'b1;
         OpStore:  begin e.sel_ALU_B = 1'b1; e.sel_imme = 3'd1; end
         OpAuipc:  begin e.sel_ALU_A = 1'b1; e.sel_ALU_B = 1'b1; e.sel_imme = 3'd4; end
         OpLui:    e.sel_imme = 3'd4;
         OpJal:    e.sel_imme = 3'd3;
         OpBranch: begin e.sel_imme = 3'd2; e.load_PC = 1'b1; e.sel_PC_B = bt; end
         default: ;
      endcase
      push(s, e);
   endtask

   // mw idle cycles then completion; mw > T models a timeout (T idle cycles + bus_err).
   task automatic m_mem(input logic [6:0] op, input int mw);
      bit    st = (op == OpStore);
      stim_t s;
      out_t  e;
      for (int i = 0; i < ((mw > T) ? T : mw); i++) begin
         s = junk(op); s.dr = 1'b0;
         e = base(3'd3); e.dmem_req = 1'b1; e.we_DM = st;
         push(s, e);
      end
      s = junk(op);
      e = base(3'd3); e.dmem_req = 1'b1;
      if (mw > T) begin
         s.dr = 1'b0; e.bus_err = 1'b1;
      end else begin
         s.dr = 1'b1; e.we_DM = st; e.load_PC = st;
      end
      push(s, e);
   endtask

   task automatic m_wb(input logic [6:0] op);
      out_t e = base(3'd4);
      e.load_PC = 1'b1;
      e.we_RF   = is_legal(op);
      case (op)
         OpLoad: e.sel_RF_in = 2'd1;
         OpLui:  e.sel_RF_in = 2'd3;
         OpJal:  begin e.sel_RF_in = 2'd2; e.sel_PC_B = 1'b1; e.sel_imme = 3'd3; end
         OpJalr: begin e.sel_RF_in = 2'd2; e.sel_PC_A = 1'b1; e.sel_PC_B = 1'b1; end
         default: ;
      endcase
      push(junk(op), e);
   endtask

   // Whole instruction: ntmo memory timeouts (each forcing a full refetch) before success.
   task automatic m_instr(input logic [6:0] op, input logic bt, input int fw, input int ntmo,
                          input int mw);
      m_fetch(fw);
      m_decode(op);
      if (!is_legal(op)) begin
`ifndef CTRL_TRAP_EN
         m_wb(op);
`endif
         return;
      end
      m_exec(op, bt);
      if (op == OpBranch) return;
      if (op == OpLoad || op == OpStore) begin
         for (int k = 0; k < ntmo; k++) begin
            m_mem(op, T + 1);
            m_fetch(0);
            m_decode(op);
            m_exec(op, bt);
         end
         m_mem(op, mw);
         if (op == OpStore) return;
      end
      m_wb(op);
   endtask

   // ---------------- drivers ----------------
   task automatic step(input stim_t s);
      opcode       = s.op;
      branch_taken = s.bt;
      imem_ready   = s.ir;
      dmem_ready   = s.dr;
      @(negedge clk);
      obs = {imem_req, dmem_req, we_DM, we_IM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B,
             load_IR, load_PC, we_RF, sel_imme, sel_RF_in, bus_err, trap, state};
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stim_t s = junk(7'($urandom));
      rst          = 1'b1;
      opcode       = s.op;
      branch_taken = s.bt;
      imem_ready   = s.ir;
      dmem_ready   = s.dr;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      stim_t s;
      out_t  e;
      do_reset();
      s = junk(7'($urandom)); s.ir = 1'b0;
      e = base(3'd0); e.imem_req = 1'b1;
      step(s);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL reset got=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_add();
      stim_t s;
      out_t  e;
      int    n = 0;
      do_reset();
      m_instr(OpR, 1'b0, 0, 0, 0);
      s = junk(7'($urandom)); s.ir = 1'b0;
      e = base(3'd0); e.imem_req = 1'b1;
      push(s, e);
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL add cyc=%0d st=%0d got=%h exp=%h", n, obs.state, obs, e);
         end
         n++;
      end
   endtask

   task automatic test_directed(input string name, input logic [6:0] op, input logic bt,
                                input int fw, input int ntmo, input int mw);
      stim_t s;
      out_t  e;
      int    n = 0;
      do_reset();
      m_instr(op, bt, fw, ntmo, mw);
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d st=%0d got=%h exp=%h", name, n, obs.state, obs, e);
         end
         n++;
      end
   endtask

   task automatic test_illegal();
      stim_t s;
      out_t  e;
      int    n = 0;
      do_reset();
      m_instr(OpIll, 1'b0, 0, 0, 0);
`ifdef CTRL_TRAP_EN
      for (int i = 0; i < 6; i++) begin
         e = base(3'd5); e.trap = 1'b1;
         push(junk(OpIll), e);
      end
`endif
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL illegal cyc=%0d st=%0d got=%h exp=%h", n, obs.state, obs, e);
         end
         n++;
      end
      do_reset();
      s = junk(OpIll); s.ir = 1'b0;
      e = base(3'd0); e.imem_req = 1'b1;
      step(s);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL illegal_exit got=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_reset_mid_mem();
      stim_t s;
      out_t  e;
      int    n = 0;
      do_reset();
      m_fetch(0);
      m_decode(OpStore);
      m_exec(OpStore, 1'b0);
      for (int i = 0; i < 3; i++) begin
         s = junk(OpStore); s.dr = 1'b0;
         e = base(3'd3); e.dmem_req = 1'b1; e.we_DM = 1'b1;
         push(s, e);
      end
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL rst_mem_pre cyc=%0d st=%0d got=%h exp=%h", n, obs.state, obs, e);
         end
         n++;
      end
      rst = 1'b1;
      dmem_ready = 1'b0;
      imem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      s = junk(OpStore); s.ir = 1'b0;
      e = base(3'd0); e.imem_req = 1'b1;
      step(s);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rst_mem got=%h exp=%h", obs, e);
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      out_t  e;
      int    n = 0;
      do_reset();
      for (int i = 0; i < 9; i++) m_instr(legal_ops[i], 1'($urandom), 0, 0, 0);
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL b2b cyc=%0d st=%0d got=%h exp=%h", n, obs.state, obs, e);
         end
         n++;
      end
   endtask

   task automatic test_random();
      stim_t      s;
      out_t       e;
      int         n = 0;
      logic [6:0] op;
      int         fw, mw, ntmo;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         op = legal_ops[$urandom_range(0, 8)];
`ifndef CTRL_TRAP_EN
         if ($urandom_range(0, 9) == 0) begin
            do op = 7'($urandom); while (is_legal(op));
         end
`endif
         fw   = ($urandom_range(0, 7) == 0) ? $urandom_range(T + 1, 2 * T + 2)
                                            : $urandom_range(0, T);
         mw   = $urandom_range(0, T);
         ntmo = ($urandom_range(0, 5) == 0) ? 1 : 0;
         m_instr(op, 1'($urandom), fw, ntmo, mw);
      end
      while (sq.size() > 0) begin
         s = sq.pop_front(); e = eq.pop_front();
         step(s);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL random cyc=%0d op=%b st=%0d got=%h exp=%h", n, s.op, obs.state,
                     obs, e);
         end
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      opcode = '0;
      branch_taken = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_directed("lw_wait3", OpLoad, 1'b0, 0, 0, 3);
      test_directed("br_taken", OpBranch, 1'b1, 0, 0, 0);
      test_directed("br_not", OpBranch, 1'b0, 0, 0, 0);
      test_directed("sw_timeout", OpStore, 1'b0, 0, 1, 0);
      test_directed("lw_mem_edge", OpLoad, 1'b0, 2, 0, T);
      test_directed("fetch_edge", OpI, 1'b0, T, 0, 0);
      test_directed("fetch_tmo", OpJal, 1'b0, T + 1, 0, 0);
      test_directed("jalr", OpJalr, 1'b1, 1, 0, 0);
      test_illegal();
      test_reset_mid_mem();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
